// File: rtl/wb_arb_defs.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM encoding,
// Wishbone data/select widths and a constant clog2 helper.
package wb_arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ERR   = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam int DW   = 32;
  localparam int SELW = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotate-priority picker: the first requester after 'last' (modulo NM) wins.
module wb_rr_pick
  import wb_arb_defs::*;
#(
  parameter int NM = 3,
  parameter int IW = 2
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NM-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    // i = NM wraps back to 'last' itself, so it has the lowest priority
    for (int i = 1; i <= NM; i++) begin
      k = (int'(last) + i) % NM;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone classic-cycle arbiter: NM masters share one slave port with
// round-robin grant and a bus-timeout watchdog that errors out hung cycles.
module wb_rr_arbiter
  import wb_arb_defs::*;
#(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  input  logic [NM*SELW-1:0]   m_sel_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  output logic [DW-1:0]        m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [SELW-1:0]      s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack_i,
  output logic [NM-1:0]        grant_o,
  output logic                 timeout_o
);

  localparam int IW = clog2(NM);

  arb_state_t      state;
  logic [NM-1:0]   grant;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   last;
  logic [TW-1:0]   cnt;
  logic [NM-1:0]   err_q;
  logic            timeout_q;

  logic [NM-1:0]   pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [AW-1:0]   sel_adr;
  logic [DW-1:0]   sel_dat;
  logic [SELW-1:0] sel_sel;
  logic            sel_we;
  logic            sel_cyc;
  logic            sel_stb;
  logic            busy;

  wb_rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_pick (
    .req  (m_cyc_i),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    sel_we  = 1'b0;
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (gidx == IW'(k)) begin
        sel_adr = m_adr_i[k*AW +: AW];
        sel_dat = m_dat_i[k*DW +: DW];
        sel_sel = m_sel_i[k*SELW +: SELW];
        sel_we  = m_we_i[k];
        sel_cyc = m_cyc_i[k];
        sel_stb = m_stb_i[k];
      end
    end
  end

  // Control strobes reach the slave only in BUSY; ERR/DRAIN/IDLE keep it quiet
  assign busy      = (state == BUSY);
  assign s_adr_o   = sel_adr;
  assign s_dat_o   = sel_dat;
  assign s_sel_o   = sel_sel;
  assign s_we_o    = busy & sel_we;
  assign s_cyc_o   = busy & sel_cyc;
  assign s_stb_o   = busy & sel_stb;
  assign m_ack_o   = (busy && s_ack_i) ? grant : '0;
  assign m_err_o   = err_q;
  assign timeout_o = timeout_q;
  assign grant_o   = grant;
  assign m_dat_o   = s_dat_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      gidx      <= '0;
      last      <= IW'(NM - 1);
      cnt       <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      err_q     <= '0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_any) begin
            grant <= pick_gnt;
            gidx  <= pick_idx;
            last  <= pick_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!sel_cyc) begin
            state <= IDLE;
            grant <= '0;
            cnt   <= '0;
          end else if (TIMEOUT != 0 && s_stb_o && !s_ack_i) begin
            // an ack in the expiry cycle takes the other branch and wins
            if (cnt == TW'(TIMEOUT - 1)) begin
              state     <= ERR;
              err_q     <= grant;
              timeout_q <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + TW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        ERR: begin
          state <= DRAIN;
        end
        DRAIN: begin
          if (!sel_cyc) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: master/slave stimulus tasks push expected
// grants and responses; independent monitors pop and compare them.
module tb_wb_rr_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;

  logic            clk;
  logic            rst;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*32-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [AW-1:0]    s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i;
  logic [NM-1:0]    grant_o;
  logic             timeout_o;

  logic [31:0] adr_r [NM];
  logic [31:0] dat_r [NM];
  logic [3:0]  sel_r [NM];
  logic        we_r  [NM];
  logic        cyc_r [NM];
  logic        stb_r [NM];

  logic        slave_ack;
  logic        late_ack;
  logic [31:0] slave_data;
  int          ack_after;
  int          scnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
  } resp_t;

  typedef struct {
    logic [2:0] mask;
    int         idle;
  } gnt_t;

  resp_t resp_q[$];
  gnt_t  gnt_q[$];

  wb_rr_arbiter #(
    .NM      (NM),
    .AW      (AW),
    .TIMEOUT (16),
    .TW      (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_we_i    (m_we_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_ack_i = slave_ack | late_ack;
  assign s_dat_i = slave_data;

  always_comb begin
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    m_we_i  = '0;
    m_cyc_i = '0;
    m_stb_i = '0;
    for (int k = 0; k < NM; k++) begin
      m_adr_i[k*AW +: AW] = adr_r[k];
      m_dat_i[k*32 +: 32] = dat_r[k];
      m_sel_i[k*4 +: 4]   = sel_r[k];
      m_we_i[k]           = we_r[k];
      m_cyc_i[k]          = cyc_r[k];
      m_stb_i[k]          = stb_r[k];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic void pushAck(input int k, input logic [31:0] adr, input logic we,
                                  input logic [31:0] wdat, input logic [31:0] rdat);
    resp_t e;
    e.ack  = 3'(1 << k);
    e.err  = 3'b000;
    e.adr  = adr;
    e.we   = we;
    e.wdat = wdat;
    e.rdat = rdat;
    resp_q.push_back(e);
  endfunction

  function automatic void pushGrant(input int k, input int idle);
    gnt_t g;
    g.mask = 3'(1 << k);
    g.idle = idle;
    gnt_q.push_back(g);
  endfunction

  // Slave: acks on the ack_after-th consecutive strobed cycle (0 = never acks)
  initial begin
    slave_ack = 1'b0;
    scnt      = 0;
    forever begin
      @(negedge clk);
      if (s_cyc_o && s_stb_o) begin
        scnt++;
        slave_ack = (ack_after != 0 && scnt == ack_after);
        if (slave_ack) scnt = 0;
      end else begin
        scnt      = 0;
        slave_ack = 1'b0;
      end
      @(posedge clk);
      #1 slave_ack = 1'b0;
    end
  end

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (m_ack_o != '0 || m_err_o != '0) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_response: got ack=%b err=%b expected none", m_ack_o, m_err_o);
        end else begin
          e = resp_q.pop_front();
          checkOutput("ack_mask", 32'(m_ack_o), 32'(e.ack));
          checkOutput("err_mask", 32'(m_err_o), 32'(e.err));
          if (e.ack != 3'b000) begin
            checkOutput("slave_adr", s_adr_o, e.adr);
            checkOutput("slave_we", 32'(s_we_o), 32'(e.we));
            if (e.we) begin
              checkOutput("slave_wdat", s_dat_o, e.wdat);
              checkOutput("slave_sel", 32'(s_sel_o), 32'hF);
            end else begin
              checkOutput("read_dat", m_dat_o, e.rdat);
            end
          end
        end
      end
    end
  end

  // Grant monitor: order of grants and dead cycles in between
  initial begin
    logic [2:0] prev;
    int         idle_run;
    gnt_t       g;
    prev     = 3'b000;
    idle_run = 0;
    forever begin
      @(negedge clk);
      #1;
      if (grant_o != 3'b000 && grant_o != prev) begin
        if (gnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_grant: got %b expected none", grant_o);
        end else begin
          g = gnt_q.pop_front();
          checkOutput("grant_order", 32'(grant_o), 32'(g.mask));
          if (g.idle >= 0) checkOutput("dead_cycles", 32'(idle_run), 32'(g.idle));
          else checkOutput("dead_gap", 32'(idle_run >= 1), 32'd1);
        end
      end
      if (grant_o == 3'b000) idle_run++;
      else idle_run = 0;
      prev = grant_o;
    end
  end

  // One master cycle of nbeats beats; returns at posedge+1 after the last beat
  task automatic applyStimulus(input int k, input int nbeats, input logic [31:0] adr,
                               input logic we, input logic [31:0] wdat);
    int budget;
    adr_r[k] = adr;
    we_r[k]  = we;
    dat_r[k] = wdat;
    sel_r[k] = 4'hF;
    cyc_r[k] = 1'b1;
    stb_r[k] = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      budget = 64;
      do begin
        @(negedge clk);
        #1;
        budget--;
      end while (!(m_ack_o[k] || m_err_o[k]) && budget > 0);
      checks++;
      if (!(m_ack_o[k] || m_err_o[k])) begin
        errors++;
        $display("[TB] FAIL wait_ack_m%0d: got no response expected ack within 64 cycles", k);
      end
      @(posedge clk);
      #1;
      if (b == nbeats - 1) begin
        cyc_r[k] = 1'b0;
        stb_r[k] = 1'b0;
      end else begin
        adr_r[k] = adr_r[k] + 32'd4;
      end
    end
  endtask

  task automatic applyReset();
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int    n;
    resp_t e;
    rst        = 1'b0;
    late_ack   = 1'b0;
    ack_after  = 0;
    slave_data = 32'h0;
    for (int k = 0; k < NM; k++) begin
      adr_r[k] = '0; dat_r[k] = '0; sel_r[k] = '0;
      we_r[k]  = 1'b0; cyc_r[k] = 1'b0; stb_r[k] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant", 32'(grant_o), 32'd0);
    checkOutput("rst_ack", 32'(m_ack_o), 32'd0);
    checkOutput("rst_err", 32'(m_err_o), 32'd0);
    checkOutput("rst_cyc", 32'(s_cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(s_stb_o), 32'd0);
    checkOutput("rst_we", 32'(s_we_o), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_o), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single master read");
    ack_after  = 2;
    slave_data = 32'hDEADBEEF;
    pushGrant(1, -1);
    pushAck(1, 32'h40000004, 1'b0, 32'h0, 32'hDEADBEEF);
    fork
      applyStimulus(1, 1, 32'h40000004, 1'b0, 32'h0);
      begin
        @(negedge clk);
        #2 checkOutput("t1_grant_c0", 32'(grant_o), 32'd0);
        @(negedge clk);
        #2 checkOutput("t1_grant_c1", 32'(grant_o), 32'b010);
        checkOutput("t1_ack_c1", 32'(m_ack_o), 32'd0);
      end
    join
    repeat (2) @(posedge clk);

    $display("[TB] round-robin fairness");
    applyReset();
    ack_after  = 1;
    slave_data = 32'h12345678;
    pushGrant(0, -1); pushGrant(1, 1); pushGrant(2, 1);
    pushGrant(0, 1);  pushGrant(1, 1); pushGrant(2, 1);
    for (int r = 0; r < 2; r++) begin
      pushAck(0, 32'h00000100, 1'b0, 32'h0, 32'h12345678);
      pushAck(1, 32'h00000200, 1'b0, 32'h0, 32'h12345678);
      pushAck(2, 32'h00000300, 1'b0, 32'h0, 32'h12345678);
    end
    fork
      repeat (2) begin applyStimulus(0, 1, 32'h00000100, 1'b0, 32'h0); @(posedge clk); #1; end
      repeat (2) begin applyStimulus(1, 1, 32'h00000200, 1'b0, 32'h0); @(posedge clk); #1; end
      repeat (2) begin applyStimulus(2, 1, 32'h00000300, 1'b0, 32'h0); @(posedge clk); #1; end
    join
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] burst hold");
    ack_after  = 2;
    slave_data = 32'hA5A50000;
    pushGrant(0, -1);
    for (int b = 0; b < 4; b++) pushAck(0, 32'h00001000 + 32'(4 * b), 1'b1, 32'hCAFE0001, 32'h0);
    pushGrant(2, 1);
    pushAck(2, 32'h00003000, 1'b0, 32'h0, 32'hA5A50000);
    fork
      applyStimulus(0, 4, 32'h00001000, 1'b1, 32'hCAFE0001);
      applyStimulus(2, 1, 32'h00003000, 1'b0, 32'h0);
    join
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] watchdog timeout");
    ack_after = 0;
    pushGrant(2, -1);
    e.ack = 3'b000; e.err = 3'b100; e.adr = '0; e.we = 1'b0; e.wdat = '0; e.rdat = '0;
    resp_q.push_back(e);
    adr_r[2] = 32'h30000010; we_r[2] = 1'b0; sel_r[2] = 4'hF;
    cyc_r[2] = 1'b1; stb_r[2] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!m_err_o[2] && n < 40);
    checkOutput("t4_err_latency", 32'(n), 32'd18);
    checkOutput("t4_timeout_pulse", 32'(timeout_o), 32'd1);
    checkOutput("t4_cyc_in_err", 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    #2;
    checkOutput("t4_timeout_one_cycle", 32'(timeout_o), 32'd0);
    checkOutput("t4_err_one_cycle", 32'(m_err_o), 32'd0);
    checkOutput("t4_drain_grant", 32'(grant_o), 32'b100);
    checkOutput("t4_drain_cyc", 32'(s_cyc_o), 32'd0);
    late_ack = 1'b1;
    #1 checkOutput("t4_late_ack_blocked", 32'(m_ack_o), 32'd0);
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    cyc_r[2] = 1'b0;
    stb_r[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 checkOutput("t4_idle_after_drop", 32'(grant_o), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] ack at expiry");
    ack_after  = 16;
    slave_data = 32'h0BADF00D;
    pushGrant(1, -1);
    pushAck(1, 32'h00005000, 1'b0, 32'h0, 32'h0BADF00D);
    pushAck(1, 32'h00005004, 1'b0, 32'h0, 32'h0BADF00D);
    applyStimulus(1, 2, 32'h00005000, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] async reset mid-transfer");
    ack_after = 0;
    pushGrant(0, -1);
    adr_r[0] = 32'h00007000; we_r[0] = 1'b0; sel_r[0] = 4'hF;
    cyc_r[0] = 1'b1; stb_r[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 checkOutput("t6_busy_before_rst", 32'(s_cyc_o), 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("t6_rst_cyc", 32'(s_cyc_o), 32'd0);
    checkOutput("t6_rst_stb", 32'(s_stb_o), 32'd0);
    checkOutput("t6_rst_grant", 32'(grant_o), 32'd0);
    checkOutput("t6_rst_err", 32'(m_err_o), 32'd0);
    cyc_r[0] = 1'b0;
    stb_r[0] = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    ack_after  = 1;
    slave_data = 32'h55AA55AA;
    pushGrant(0, -1); pushGrant(1, 1); pushGrant(2, 1);
    pushAck(0, 32'h00008000, 1'b0, 32'h0, 32'h55AA55AA);
    pushAck(1, 32'h00009000, 1'b0, 32'h0, 32'h55AA55AA);
    pushAck(2, 32'h0000A000, 1'b0, 32'h0, 32'h55AA55AA);
    fork
      applyStimulus(0, 1, 32'h00008000, 1'b0, 32'h0);
      applyStimulus(1, 1, 32'h00009000, 1'b0, 32'h0);
      applyStimulus(2, 1, 32'h0000A000, 1'b0, 32'h0);
    join

    repeat (4) @(posedge clk);
    #1;
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    checkOutput("grant_queue_drained", 32'(gnt_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL global_timeout: got no end of test expected finish before 200000ns");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
